feature_buffer_responder: RTL and testbench
===========================================

FEATURE_BUFFER_RESPONDER -- requirements
Module: feature_buffer_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the stored word.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter RSP_DEPTH, default 4, response FIFO entries; also the maximum number of outstanding requests.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 base_addr  input  32  global byte-independent word address mapped to local word 0; quasi-static.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted when high with req_valid.
REQ-009 wr_rd_req  input  1  request type: 1 = write, 0 = read.
REQ-010 req_addr  input  32  global word address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-015 rsp_err  output  1  request was out of range.
REQ-016 rsp_is_wr  output  1  response belongs to a write.
REQ-017 rd_cnt, wr_cnt, err_cnt  output  16 each  accepted reads, accepted in-range writes, errors; saturating at 0xFFFF.

Function
REQ-018 Accept = req_valid & req_ready; exactly one response per accepted request, in acceptance order.
REQ-019 local = req_addr - base_addr (32-bit); in range iff req_addr >= base_addr and local < DEPTH; memory indexed by local[ADDR_W-1:0].
REQ-020 Accepted in-range write SHALL update memory at the acceptance edge.
REQ-021 Accepted in-range read SHALL register the memory word one edge after acceptance; its response enters the FIFO on the second edge.
REQ-022 Writes and errors traverse the same 2-stage pipeline as reads so ordering is preserved; no memory access on error.
REQ-023 Latency: with empty FIFO, rsp_valid rises exactly 2 cycles after the acceptance edge.
REQ-024 Read accepted the cycle after a write to the same address SHALL return the new data.
REQ-025 req_ready = (pipeline occupancy + FIFO count) < RSP_DEPTH, computed from registered state only; no combinational path from req_valid or rsp_ready.
REQ-026 FIFO SHALL be show-ahead; rsp_* stable while rsp_valid & !rsp_ready.
REQ-027 Simultaneous push and pop on full FIFO SHALL be legal; count unchanged.
REQ-028 Back-to-back acceptance at one request per cycle SHALL be sustained while rsp_ready stays high.
REQ-029 Counters increment on acceptance (err_cnt instead of rd/wr_cnt for out-of-range); hold at 0xFFFF.

Reset
REQ-030 rst_n low SHALL immediately clear pipeline, FIFO and counters: rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_is_wr=0, all counters 0, req_ready=0.
REQ-031 req_ready SHALL be 1 in the first cycle after rst_n deasserts; memory contents are not reset.
REQ-032 Reset mid-operation SHALL discard all outstanding responses; none emerge after release.

Verification
REQ-033 base_addr=0x100; write 0x100->0xDEADBEEF, read 0x100 -> read response rdata=0xDEADBEEF, err=0, 2 cycles after read acceptance.
REQ-034 rsp_ready=0, issue 6 reads -> exactly 4 accepted, req_ready=0 afterwards; raise rsp_ready -> 4 in-order responses, then req_ready=1.
REQ-035 base_addr=0x100; read 0xFF and 0x100+DEPTH -> two responses err=1, rdata=0; err_cnt=2; memory unchanged.
REQ-036 Write addr A data 0x5 then read A next cycle -> rdata=0x5; stream of 8 reads with rsp_ready=1 -> req_ready never drops, 8 responses in 8 consecutive cycles.
REQ-037 3 reads outstanding, assert rst_n=0 one cycle -> rsp_valid=0 immediately, no responses after release, counters 0.
REQ-038 Preload wr_cnt near 0xFFFF by 65540 writes -> wr_cnt holds 0xFFFF.

Source files
------------

// File: rtl/feature_buffer_responder.sv
// Word-addressed feature buffer: reads/writes in a 2-stage pipeline, responses queued in order.
// Latency 2 cycles from acceptance to rsp_valid (empty FIFO); req_ready drops once RSP_DEPTH requests are in flight.
// Backpressure: rsp_ready low stalls the response FIFO and, through the in-flight count, stops new requests.

module resp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     pop_dat,
    output logic [CNT_W-1:0] cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  buf_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && (cnt != '0);
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = buf_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            buf_q[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module feature_buffer_responder #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr_rd_req,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_is_wr,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       err_cnt
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 1;

    typedef struct packed {
        logic              is_wr;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       local_addr;
    logic              in_range;
    logic              accept;

    logic              s1_vld;
    logic              s1_wr;
    logic              s1_err;
    logic [ADDR_W-1:0] s1_idx;

    logic              s2_vld;
    logic              s2_wr;
    logic              s2_err;
    logic [DATA_W-1:0] rd_word;

    rsp_t              push_dat;
    rsp_t              head_dat;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [OCC_W-1:0]  occupancy;

    assign local_addr = req_addr - base_addr;
    assign in_range   = (req_addr >= base_addr) && (local_addr < 32'(DEPTH));

    // Every in-flight request owns a FIFO slot, so the FIFO can never overflow.
    assign occupancy = OCC_W'(s1_vld) + OCC_W'(s2_vld) + OCC_W'(fifo_cnt);
    assign req_ready = rst_n && (occupancy < OCC_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (accept && in_range && wr_rd_req) begin
            mem[local_addr[ADDR_W-1:0]] <= req_wdata;
        end
    end

    // Read lands one edge after acceptance, so a write accepted earlier is already visible.
    always_ff @(posedge clk) begin
        rd_word <= mem[s1_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_wr  <= 1'b0;
            s1_err <= 1'b0;
            s1_idx <= '0;
            s2_vld <= 1'b0;
            s2_wr  <= 1'b0;
            s2_err <= 1'b0;
        end else begin
            s1_vld <= accept;
            s1_wr  <= wr_rd_req;
            s1_err <= !in_range;
            s1_idx <= local_addr[ADDR_W-1:0];
            s2_vld <= s1_vld;
            s2_wr  <= s1_wr;
            s2_err <= s1_err;
        end
    end

    always_comb begin
        push_dat       = '0;
        push_dat.is_wr = s2_wr;
        push_dat.err   = s2_err;
        push_dat.rdata = (s2_wr || s2_err) ? '0 : rd_word;
    end

    resp_fifo #(
        .W     ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (s2_vld),
        .push_dat (push_dat),
        .pop      (rsp_valid && rsp_ready),
        .pop_dat  (head_dat),
        .cnt      (fifo_cnt)
    );

    // FIFO storage is not reset; gating keeps the outputs at zero when empty.
    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_rdata = rsp_valid ? head_dat.rdata : '0;
    assign rsp_err   = rsp_valid && head_dat.err;
    assign rsp_is_wr = rsp_valid && head_dat.is_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            if (!in_range) begin
                err_cnt <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
            end else if (wr_rd_req) begin
                wr_cnt <= (wr_cnt == 16'hFFFF) ? wr_cnt : wr_cnt + 16'd1;
            end else begin
                rd_cnt <= (rd_cnt == 16'hFFFF) ? rd_cnt : rd_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_feature_buffer_responder.sv
// Directed bench for feature_buffer_responder with a queue-based response scoreboard.
module tb_feature_buffer_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] base_addr;
    logic        req_valid;
    logic        req_ready;
    logic        wr_rd_req;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_is_wr;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic [15:0] err_cnt;

    feature_buffer_responder #(.DATA_W(32), .DEPTH(1024), .RSP_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_addr (base_addr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .wr_rd_req (wr_rd_req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_is_wr (rsp_is_wr),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic        err;
        logic [31:0] rdata;
        bit          lat;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer one request for up to 'tries' cycles; on acceptance queue its expected response.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata, input bit lat,
                        input int tries, output bit acc);
        exp_t e;
        req_valid = 1'b1;
        wr_rd_req = wr;
        req_addr  = addr;
        req_wdata = wdata;
        acc = 1'b0;
        for (int t = 0; t < tries && !acc; t++) begin
            @(negedge clk);
            if (req_ready) begin
                acc       = 1'b1;
                e.is_wr   = wr;
                e.err     = exp_err;
                e.rdata   = exp_rdata;
                e.lat     = lat;
                e.acc_cyc = cyc + 1;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic send_chk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic exp_err, input logic [31:0] exp_rdata, input bit lat);
        bit acc;
        send(wr, addr, wdata, exp_err, exp_rdata, lat, 20, acc);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_left", q.size(), 0);
    endtask

    // Monitor: pops expectations on each handshake and checks hold-stability under stall.
    logic        hold = 1'b0;
    logic [34:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) chk("stall_stable", {rsp_valid, rsp_is_wr, rsp_err, rsp_rdata}, held);
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got wr=%0b err=%0b rdata=0x%0h, expected no response",
                             rsp_is_wr, rsp_err, rsp_rdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp", {rsp_is_wr, rsp_err, rsp_rdata}, {e.is_wr, e.err, e.rdata});
                    if (e.lat) chk("latency", cyc - e.acc_cyc, 2);
                end
            end
            hold = rsp_valid && !rsp_ready;
            held = {rsp_valid, rsp_is_wr, rsp_err, rsp_rdata};
        end
    end

    initial begin
        bit acc;
        int n_acc;
        rst_n     = 1'b0;
        base_addr = 32'h100;
        req_valid = 1'b0;
        wr_rd_req = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        #3;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_counters", {rd_cnt, wr_cnt, err_cnt}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);
        @(posedge clk);
        #1;

        // Write then read back, checking 2-cycle latency.
        send_chk(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        send_chk(1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        drain();
        chk("cnt_a", {rd_cnt, wr_cnt, err_cnt}, {16'd1, 16'd1, 16'd0});

        // Out-of-range: below base and one past the top.
        send_chk(1'b0, 32'hFF, 32'h0, 1'b1, 32'h0, 1'b0);
        send_chk(1'b0, 32'h500, 32'h0, 1'b1, 32'h0, 1'b0);
        drain();
        chk("err_cnt_2", err_cnt, 2);
        chk("rd_cnt_err", rd_cnt, 1);
        // 0x500 would alias word 0 if the range check were missing.
        send_chk(1'b1, 32'h500, 32'h12345678, 1'b1, 32'h0, 1'b0);
        send_chk(1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        drain();
        chk("cnt_b", {rd_cnt, wr_cnt, err_cnt}, {16'd2, 16'd1, 16'd3});

        // Read-after-write next cycle, then a back-to-back stream.
        send_chk(1'b1, 32'h105, 32'h5, 1'b0, 32'h0, 1'b1);
        send_chk(1'b0, 32'h105, 32'h0, 1'b0, 32'h5, 1'b1);
        for (int i = 0; i < 8; i++)
            send_chk(1'b1, 32'h110 + i, 32'hC0DE0000 + i, 1'b0, 32'h0, 1'b1);
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 32'h110 + i, 32'h0, 1'b0, 32'hC0DE0000 + i, 1'b1, 1, acc);
            if (acc) n_acc++;
        end
        chk("stream_accepted", n_acc, 8);
        drain();
        chk("cnt_c", {rd_cnt, wr_cnt, err_cnt}, {16'd11, 16'd10, 16'd3});

        // Backpressure: only RSP_DEPTH requests may be outstanding.
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 32'h110 + i, 32'h0, 1'b0, 32'hC0DE0000 + i, 1'b0, 1, acc);
            if (acc) n_acc++;
        end
        chk("bp_accepted", n_acc, 4);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_ready_low", req_ready, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_ready_high", req_ready, 1);
        @(posedge clk);
        #1;

        // Reset with responses outstanding.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_chk(1'b0, 32'h110 + i, 32'h0, 1'b0, 32'hC0DE0000 + i, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_valid", rsp_valid, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        q.delete();
        chk("rst_outputs", {rsp_valid, rsp_err, rsp_is_wr, rsp_rdata}, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_counters", {rd_cnt, wr_cnt, err_cnt}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("rel_counters", {rd_cnt, wr_cnt, err_cnt}, 0);
        send_chk(1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        drain();

        // Saturate the write counter.
        n_acc = 0;
        for (int i = 0; i < 65540; i++) begin
            send(1'b1, 32'h200, i, 1'b0, 32'h0, 1'b0, 1, acc);
            if (acc) n_acc++;
        end
        chk("sat_accepted", n_acc, 65540);
        drain();
        chk("wr_cnt_sat", wr_cnt, 16'hFFFF);
        chk("cnt_after_sat", {rd_cnt, err_cnt}, {16'd1, 16'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
